// File: rtl/matrix_result_streamer_if.sv
// Handshake bundle between the matrix multiplier output and the element stream
// consumer. The streamer takes the slave side; the producer/consumer pair
// around it takes the master side.
interface matrix_result_streamer_if #(
  parameter int BIT_SIZE     = 8,
  parameter int ROW_COL_SIZE = 3
);
  localparam int OUT_M_BIT_SIZE           = BIT_SIZE*2 + $clog2(ROW_COL_SIZE);
  localparam int OUT_M_LINE_SIZE          = OUT_M_BIT_SIZE*ROW_COL_SIZE;
  localparam int UNPACKED_OUT_MATRIX_SIZE = OUT_M_LINE_SIZE*ROW_COL_SIZE;
  localparam int IDX_W                    = $clog2(ROW_COL_SIZE);

  logic                                in_valid;
  logic                                in_ready;
  logic [0:UNPACKED_OUT_MATRIX_SIZE-1] in_m;
  logic                                out_valid;
  logic                                out_ready;
  logic [OUT_M_BIT_SIZE-1:0]           out_data;
  logic [IDX_W-1:0]                    out_row;
  logic [IDX_W-1:0]                    out_col;
  logic                                out_last;

  modport master (
    output in_valid, in_m, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last
  );

  modport slave (
    input  in_valid, in_m, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last
  );
endinterface

// File: rtl/matrix_result_streamer.sv
// Captures a packed N x N product matrix and replays it one element per
// valid/ready beat, tagged with its row/column and a last-element flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a matrix; in_ready=1, out_valid=0
// S_STREAM| buffer holds a matrix; presenting element (row_q, col_q)
module matrix_result_streamer #(
  parameter int BIT_SIZE                 = 8,
  parameter int ROW_COL_SIZE             = 3,
  parameter int OUT_M_BIT_SIZE           = BIT_SIZE*2 + $clog2(ROW_COL_SIZE),
  parameter int OUT_M_LINE_SIZE          = OUT_M_BIT_SIZE*ROW_COL_SIZE,
  parameter int UNPACKED_OUT_MATRIX_SIZE = OUT_M_LINE_SIZE*ROW_COL_SIZE,
  parameter bit COL_MAJOR                = 1'b0,
  parameter int IDX_W                    = $clog2(ROW_COL_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  output logic                     busy,
  matrix_result_streamer_if.slave  bus
);
  localparam int N      = ROW_COL_SIZE;
  localparam int OB     = OUT_M_BIT_SIZE;
  localparam int BUF_AW = $clog2(N*N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [OB-1:0]    data_q, data_d;
  logic             last_q, last_d;
  logic [OB-1:0]    buf_q [N*N];
  logic [OB-1:0]    buf_d [N*N];

  logic [IDX_W-1:0]  nxt_row, nxt_col;
  logic [BUF_AW-1:0] nxt_idx;

  // Position of the element that follows (row_q, col_q) in the chosen order.
  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q;
    if (!COL_MAJOR) begin
      if (col_q == LAST_IDX) begin
        nxt_col = '0;
        nxt_row = row_q + 1'b1;
      end else begin
        nxt_col = col_q + 1'b1;
      end
    end else begin
      if (row_q == LAST_IDX) begin
        nxt_row = '0;
        nxt_col = col_q + 1'b1;
      end else begin
        nxt_row = row_q + 1'b1;
      end
    end
    nxt_idx = BUF_AW'(nxt_row) * BUF_AW'(N) + BUF_AW'(nxt_col);
  end

  // FSM next state: capture in IDLE, advance on each accepted beat in STREAM.
  // Element (0,0) is loaded straight from in_m so it is presented on the
  // cycle after capture; later elements come from the buffer.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    last_d  = last_q;
    buf_d   = buf_q;
    if (flush) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      data_d  = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                buf_d[r*N + c] = bus.in_m[r*OUT_M_LINE_SIZE + c*OB +: OB];
              end
            end
            data_d  = bus.in_m[0 +: OB];
            row_d   = '0;
            col_d   = '0;
            last_d  = 1'b0;
            state_d = S_STREAM;
          end
        end
        S_STREAM: begin
          if (bus.out_ready) begin
            if (last_q) begin
              state_d = S_IDLE;
              row_d   = '0;
              col_d   = '0;
              data_d  = '0;
              last_d  = 1'b0;
            end else begin
              row_d  = nxt_row;
              col_d  = nxt_col;
              data_d = buf_q[nxt_idx];
              last_d = (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, tag and data registers; reset clears the capture buffer as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < N*N; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      last_q  <= last_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_STREAM);
  assign busy          = (state_q == S_STREAM);
  assign bus.out_data  = data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench: one row-major and one column-major streamer share the same
// stimulus; each step checks outputs 1 time unit after the rising edge.
module tb_matrix_result_streamer;
  localparam int BS   = 8;
  localparam int N    = 3;
  localparam int OB   = 18;
  localparam int LINE = OB*N;
  localparam int MW   = LINE*N;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy_r, busy_c;

  always #5 clk = ~clk;

  matrix_result_streamer_if #(.BIT_SIZE(BS), .ROW_COL_SIZE(N)) if_r ();
  matrix_result_streamer_if #(.BIT_SIZE(BS), .ROW_COL_SIZE(N)) if_c ();

  assign if_c.in_valid  = if_r.in_valid;
  assign if_c.in_m      = if_r.in_m;
  assign if_c.out_ready = if_r.out_ready;

  matrix_result_streamer #(.BIT_SIZE(BS), .ROW_COL_SIZE(N), .COL_MAJOR(1'b0)) u_row (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy_r), .bus(if_r.slave));

  matrix_result_streamer #(.BIT_SIZE(BS), .ROW_COL_SIZE(N), .COL_MAJOR(1'b1)) u_col (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy_c), .bus(if_c.slave));

  int n_assert = 0;
  int n_fail   = 0;

  // Expected element values of the 10*r+c matrix in each streaming order.
  int exp_rm [9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
  int exp_cm [9] = '{0, 10, 20, 1, 11, 21, 2, 12, 22};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_row_beat(input string tag, input int r, input int c, input int d, input logic l);
    chk({tag, "_valid"}, if_r.out_valid, 1);
    chk({tag, "_data"},  if_r.out_data,  d);
    chk({tag, "_row"},   if_r.out_row,   r);
    chk({tag, "_col"},   if_r.out_col,   c);
    chk({tag, "_last"},  if_r.out_last,  l);
  endtask

  task automatic chk_col_beat(input string tag, input int r, input int c, input int d, input logic l);
    chk({tag, "_valid"}, if_c.out_valid, 1);
    chk({tag, "_data"},  if_c.out_data,  d);
    chk({tag, "_row"},   if_c.out_row,   r);
    chk({tag, "_col"},   if_c.out_col,   c);
    chk({tag, "_last"},  if_c.out_last,  l);
  endtask

  function automatic logic [0:MW-1] mk(input int base);
    logic [0:MW-1] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r*LINE + c*OB +: OB] = OB'(base + 10*r + c);
    return m;
  endfunction

  initial begin
    logic [0:MW-1] m;
    rst = 1'b1;
    flush = 1'b0;
    if_r.in_valid  = 1'b0;
    if_r.in_m      = '0;
    if_r.out_ready = 1'b0;

    // Reset values
    #2;
    chk("rst_in_ready",  if_r.in_ready,  1);
    chk("rst_out_valid", if_r.out_valid, 0);
    chk("rst_out_data",  if_r.out_data,  0);
    chk("rst_out_row",   if_r.out_row,   0);
    chk("rst_out_col",   if_r.out_col,   0);
    chk("rst_out_last",  if_r.out_last,  0);
    chk("rst_busy",      busy_r,         0);
    chk("rst_busy_c",    busy_c,         0);
    step;
    rst = 1'b0;
    step;

    // Row-major and column-major full stream, out_ready held high
    if_r.in_m = mk(0);
    if_r.in_valid = 1'b1;
    if_r.out_ready = 1'b1;
    step;
    if_r.in_valid = 1'b0;
    if_r.in_m = '1;
    chk("s1_in_ready", if_r.in_ready, 0);
    chk("s1_busy", busy_r, 1);
    for (int i = 0; i < 9; i++) begin
      chk_row_beat($sformatf("rm%0d", i), i/3, i%3, exp_rm[i], i == 8);
      chk_col_beat($sformatf("cm%0d", i), i%3, i/3, exp_cm[i], i == 8);
      step;
    end
    chk("s1_end_valid", if_r.out_valid, 0);
    chk("s1_end_ready", if_r.in_ready, 1);
    chk("s1_end_valid_c", if_c.out_valid, 0);
    chk("s1_end_busy", busy_r, 0);

    // Backpressure: out_ready low for 3 cycles while (0,1) is presented
    if_r.in_m = mk(0);
    if_r.in_valid = 1'b1;
    step;
    if_r.in_valid = 1'b0;
    chk_row_beat("bp0", 0, 0, 0, 1'b0);
    step;
    chk_row_beat("bp1", 0, 1, 1, 1'b0);
    if_r.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      chk_row_beat($sformatf("bp_hold%0d", k), 0, 1, 1, 1'b0);
    end
    if_r.out_ready = 1'b1;
    step;
    for (int i = 2; i < 9; i++) begin
      chk_row_beat($sformatf("bp%0d", i), i/3, i%3, exp_rm[i], i == 8);
      step;
    end
    chk("bp_end_valid", if_r.out_valid, 0);

    // Full-width element at (2,2), all others zero
    m = '0;
    m[2*LINE + 2*OB +: OB] = 18'h3FFFF;
    if_r.in_m = m;
    if_r.in_valid = 1'b1;
    step;
    if_r.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wide_rm%0d", i), if_r.out_data, 0);
      chk($sformatf("wide_cm%0d", i), if_c.out_data, 0);
      chk($sformatf("wide_last%0d", i), if_r.out_last, 0);
      step;
    end
    chk_row_beat("wide_rm8", 2, 2, 18'h3FFFF, 1'b1);
    chk_col_beat("wide_cm8", 2, 2, 18'h3FFFF, 1'b1);
    step;

    // Asynchronous reset in the middle of a stream
    if_r.in_m = mk(0);
    if_r.in_valid = 1'b1;
    step;
    if_r.in_valid = 1'b0;
    repeat (4) step;
    chk_row_beat("pre_rst", 1, 1, 11, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_valid", if_r.out_valid, 0);
    chk("arst_ready", if_r.in_ready, 1);
    chk("arst_busy",  busy_r, 0);
    chk("arst_data",  if_r.out_data, 0);
    chk("arst_row",   if_r.out_row, 0);
    chk("arst_col",   if_r.out_col, 0);
    step;
    rst = 1'b0;
    chk("post_rst_ready", if_r.in_ready, 1);
    if_r.in_m = mk(100);
    if_r.in_valid = 1'b1;
    step;
    if_r.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk_row_beat($sformatf("rst_new%0d", i), i/3, i%3, 100 + exp_rm[i], i == 8);
      step;
    end

    // Flush after 5 beats while in_valid stays high with a different matrix
    if_r.in_m = mk(0);
    if_r.in_valid = 1'b1;
    step;
    if_r.in_m = mk(200);
    for (int i = 0; i < 5; i++) begin
      chk_row_beat($sformatf("fl_a%0d", i), i/3, i%3, exp_rm[i], 1'b0);
      step;
    end
    chk_row_beat("fl_a5", 1, 2, 12, 1'b0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("fl_valid", if_r.out_valid, 0);
    chk("fl_valid_c", if_c.out_valid, 0);
    chk("fl_row", if_r.out_row, 0);
    chk("fl_col", if_r.out_col, 0);
    chk("fl_last", if_r.out_last, 0);
    chk("fl_ready", if_r.in_ready, 1);
    chk("fl_busy", busy_r, 0);
    step;
    if_r.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk_row_beat($sformatf("fl_b%0d", i), i/3, i%3, 200 + exp_rm[i], i == 8);
      step;
    end
    chk("fl_end_valid", if_r.out_valid, 0);
    chk("fl_end_ready", if_r.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
